// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and
// performance counters for a classic five-stage pipeline front end.
// Redirects (jump or taken branch) squash the IF/ID slot and cost one bubble.
// Load-use stalls freeze the PC and IF/ID. When start_i is low, everything holds.
module if_stage (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        stall_i,
   input  logic        jump_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_data_i,
   output logic [31:0] pc_o,
   output logic [31:0] if_id_instr_o,
   output logic [31:0] if_id_pc4_o,
   output logic        if_id_valid_o,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o,
   output logic [31:0] cycle_cnt_o
);

   logic        flush;
   logic [31:0] pc_plus4;
   logic [31:0] jump_target;
   logic [31:0] redirect_pc;

   // Next-PC candidates and the redirect decision; a jump beats a taken branch.
   always_comb begin
      flush       = jump_i | branch_taken_i;
      pc_plus4    = pc_o + 32'd4;
      jump_target = {if_id_pc4_o[31:28], if_id_instr_o[25:0], 2'b00};
      if (jump_i) begin
         redirect_pc = jump_target;
      end else begin
         redirect_pc = {branch_target_i[31:2], 2'b00};
      end
   end

   assign imem_addr_o = pc_o;

   // PC register: redirect, hold on stall/idle, otherwise advance by one word.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_o <= '0;
      end else if (start_i) begin
         if (flush) begin
            pc_o <= redirect_pc;
         end else if (!stall_i) begin
            pc_o <= {pc_plus4[31:2], 2'b00};
         end
      end
   end

   // IF/ID register: a redirect inserts a nop bubble, a stall holds the slot.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         if_id_instr_o <= '0;
         if_id_pc4_o   <= '0;
         if_id_valid_o <= 1'b0;
      end else if (start_i) begin
         if (flush) begin
            if_id_instr_o <= '0;
            if_id_pc4_o   <= '0;
            if_id_valid_o <= 1'b0;
         end else if (!stall_i) begin
            if_id_instr_o <= imem_data_i;
            if_id_pc4_o   <= pc_plus4;
            if_id_valid_o <= 1'b1;
         end
      end
   end

   // Free-running wrap-around counters; a flush masks a coincident stall.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_o <= '0;
         flush_cnt_o <= '0;
         cycle_cnt_o <= '0;
      end else if (start_i) begin
         cycle_cnt_o <= cycle_cnt_o + 32'd1;
         if (flush) begin
            flush_cnt_o <= flush_cnt_o + 32'd1;
         end else if (stall_i) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
         end
      end
   end

endmodule
